day_step_ctrl: RTL and testbench

Run/pause/rate sequencer for the day-of-year counter on the DE10-Lite board. It debounces the raw KEY pushbuttons and runs a STOPPED/RUNNING state machine with a slow/fast rate flag. It emits single-cycle `step` and `clear` enables, so the 1–99 day counter and its display path run synchronously on `clk`. This replaces the divided-clock and latched-key scheme.

---
 rtl/day_step_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_day_step_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day_step_ctrl.sv
// day_step_ctrl: run/pause/rate sequencer for the day-of-year counter.
// Debounces three raw active-low keys and turns them into a STOPPED/RUNNING
// state, a slow/fast rate flag and single-cycle step/clear enables, so the
// day counter and display path run on clk without any divided clock.
// Every output comes straight from a register: a press event seen in cycle e
// shows up on running/fast/clear in cycle e+1, and the first step after it
// follows DIV cycles after that.

module day_step_key #(
    parameter int unsigned DEBOUNCE = 200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);
    localparam int unsigned   CW        = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    logic          meta_q;
    logic          sync_q;
    logic          acc_q;
    logic          acc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Two-flop synchronizer; both stages rest at the released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= key_n_i;
            sync_q <= meta_q;
        end
    end

    // Accept a new level only after it has differed from the accepted one for DEBOUNCE+1 cycles.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        press_d = 1'b0;
        if (sync_q == acc_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LIMIT) begin
            cnt_d   = CNT_ZERO;
            acc_d   = sync_q;
            press_d = ~sync_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Debounce counter, accepted level and one-cycle press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= CNT_ZERO;
            acc_q   <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

module day_step_ctrl #(
    parameter int unsigned SLOW_DIV = 10_000_000,
    parameter int unsigned FAST_DIV = 2_500_000,
    parameter int unsigned DEBOUNCE = 200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_run_n,
    input  logic key_rate_n,
    input  logic key_clr_n,
    output logic step,
    output logic clear,
    output logic running,
    output logic fast,
    output logic blink
);
    localparam int unsigned   PW        = $clog2(SLOW_DIV);
    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [PW-1:0] PRE_ZERO  = PW'(0);

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic          fast_q;
    logic          fast_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          step_q;
    logic          step_d;
    logic          clear_q;
    logic          clear_d;
    logic          blink_q;
    logic          blink_d;

    logic          run_ev_s;
    logic          rate_ev_s;
    logic          clr_ev_s;
    logic          any_ev_s;
    logic [PW-1:0] limit_s;
    logic          term_s;

    day_step_key #(.DEBOUNCE(DEBOUNCE)) u_key_run (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_run_n),
        .press_o (run_ev_s)
    );

    day_step_key #(.DEBOUNCE(DEBOUNCE)) u_key_rate (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_rate_n),
        .press_o (rate_ev_s)
    );

    day_step_key #(.DEBOUNCE(DEBOUNCE)) u_key_clr (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_clr_n),
        .press_o (clr_ev_s)
    );

    // Any press restarts the period, so the prescaler never compares against a stale limit.
    assign any_ev_s = run_ev_s | rate_ev_s | clr_ev_s;
    assign limit_s  = fast_q ? FAST_LAST : SLOW_LAST;
    assign term_s   = (state_q == ST_RUNNING) && (pre_q == limit_s);

    // Next state, rate, prescaler and output pulses; a press in a terminal-count cycle swallows that step.
    always_comb begin
        state_d = state_q;
        fast_d  = fast_q;
        pre_d   = pre_q;
        step_d  = 1'b0;
        clear_d = clr_ev_s;
        blink_d = blink_q;

        case (state_q)
            ST_STOPPED: begin
                if (run_ev_s) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_STOPPED;
                end
            end
            ST_RUNNING: begin
                if (run_ev_s) begin
                    state_d = ST_STOPPED;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase

        if (rate_ev_s) begin
            fast_d = ~fast_q;
        end else begin
            fast_d = fast_q;
        end

        if (any_ev_s || (state_q != ST_RUNNING)) begin
            pre_d = PRE_ZERO;
        end else if (term_s) begin
            pre_d  = PRE_ZERO;
            step_d = 1'b1;
        end else begin
            pre_d = pre_q + PRE_ONE;
        end

        if (state_d != ST_RUNNING) begin
            blink_d = 1'b0;
        end else if (step_d) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    // State, rate, prescaler and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STOPPED;
            fast_q  <= 1'b0;
            pre_q   <= PRE_ZERO;
            step_q  <= 1'b0;
            clear_q <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fast_q  <= fast_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
            clear_q <= clear_d;
            blink_q <= blink_d;
        end
    end

    assign step    = step_q;
    assign clear   = clear_q;
    assign running = (state_q == ST_RUNNING);
    assign fast    = fast_q;
    assign blink   = blink_q;
endmodule

// File: tb/tb_day_step_ctrl.sv
// Bench for day_step_ctrl: directed scenarios with literal timing pins plus a
// randomized key phase, all checked every cycle against a behavioural model
// that schedules steps in absolute time and debounces from a raw-sample history.
`timescale 1ns/1ps

module tb_day_step_ctrl;
    localparam int SLOW = 8;
    localparam int FAST = 4;
    localparam int DEB  = 3;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic key_run_n  = 1'b1;
    logic key_rate_n = 1'b1;
    logic key_clr_n  = 1'b1;
    logic step;
    logic clear;
    logic running;
    logic fast;
    logic blink;

    int checks   = 0;
    int failures = 0;
    int step_cnt = 0;

    day_step_ctrl #(
        .SLOW_DIV (SLOW),
        .FAST_DIV (FAST),
        .DEBOUNCE (DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_run_n  (key_run_n),
        .key_rate_n (key_rate_n),
        .key_clr_n  (key_clr_n),
        .step       (step),
        .clear      (clear),
        .running    (running),
        .fast       (fast),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] hist [3];   // raw key samples, bit 0 = most recent edge
    bit          acc  [3];   // accepted key level
    bit          ev   [3];   // press event visible in the current cycle
    bit          m_run, m_fast, m_step, m_clear, m_blink;
    longint      cyc;        // index of the most recently modelled edge
    longint      next_step;  // absolute edge at which the next step appears

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            hist[k] = 16'hFFFF;
            acc[k]  = 1'b1;
            ev[k]   = 1'b0;
        end
        m_run   = 1'b0;
        m_fast  = 1'b0;
        m_step  = 1'b0;
        m_clear = 1'b0;
        m_blink = 1'b0;
    endtask

    // Predict outputs after the coming edge from the keys it will sample.
    task automatic m_advance();
        bit raw [3];
        bit any_ev;
        bit all_diff;
        raw[0] = key_run_n;
        raw[1] = key_rate_n;
        raw[2] = key_clr_n;
        cyc++;
        any_ev  = ev[0] | ev[1] | ev[2];
        m_clear = ev[2];
        if (any_ev) begin
            m_step    = 1'b0;
            next_step = cyc + (((m_fast ^ ev[1]) != 1'b0) ? FAST : SLOW);
        end else if (m_run && (cyc == next_step)) begin
            m_step    = 1'b1;
            next_step = cyc + (m_fast ? FAST : SLOW);
        end else begin
            m_step = 1'b0;
        end
        m_run  = m_run ^ ev[0];
        m_fast = m_fast ^ ev[1];
        if (!m_run) m_blink = 1'b0;
        else if (m_step) m_blink = ~m_blink;
        // A key level is accepted once the synchronized level (two edges old)
        // has differed from the accepted level for DEB+1 consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            hist[k] = {hist[k][14:0], raw[k]};
            ev[k]   = 1'b0;
            all_diff = 1'b1;
            for (int j = 2; j <= DEB + 2; j++) begin
                if (hist[k][j] == acc[k]) all_diff = 1'b0;
            end
            if (all_diff) begin
                acc[k] = ~acc[k];
                ev[k]  = (acc[k] == 1'b0);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Compare every cycle on the falling edge, then advance the model.
    initial begin
        cyc       = 0;
        next_step = 0;
        m_reset();
        forever begin
            @(negedge clk);
            if (!reset) m_reset();
            chk("step",    {31'd0, step},    {31'd0, m_step});
            chk("clear",   {31'd0, clear},   {31'd0, m_clear});
            chk("running", {31'd0, running}, {31'd0, m_run});
            chk("fast",    {31'd0, fast},    {31'd0, m_fast});
            chk("blink",   {31'd0, blink},   {31'd0, m_blink});
            chk("step_clear_excl", {31'd0, step & clear}, 32'd0);
            if (step === 1'b1) step_cnt++;
            if (reset) m_advance();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int max_n, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while ((step !== 1'b1) && (n < max_n));
    endtask

    initial begin
        int n;
        int sc;
        int hold [3];
        bit lvl;

        // 1: reset and idle
        tick(3);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_fast",    {31'd0, fast},    32'd0);
        reset = 1'b1;
        tick(50);
        chk("idle_steps", step_cnt, 32'd0);
        chk("idle_running", {31'd0, running}, 32'd0);

        // 2: start in slow rate
        key_run_n = 1'b0;
        tick(6);
        chk("run_lat6", {31'd0, running}, 32'd0);
        tick(1);
        chk("run_lat7", {31'd0, running}, 32'd1);
        wait_step(40, n);
        chk("slow_first", n, 32'd8);
        chk("blink_first", {31'd0, blink}, 32'd1);
        wait_step(40, n);
        chk("slow_space", n, 32'd8);
        chk("blink_second", {31'd0, blink}, 32'd0);
        tick(30);
        key_run_n = 1'b1;
        chk("long_press_running", {31'd0, running}, 32'd1);
        tick(10);

        // 3: rate change mid-period
        key_rate_n = 1'b0;
        tick(7);
        chk("fast_set", {31'd0, fast}, 32'd1);
        wait_step(40, n);
        chk("fast_first", n, 32'd4);
        wait_step(40, n);
        chk("fast_space", n, 32'd4);
        key_rate_n = 1'b1;
        tick(10);
        key_rate_n = 1'b0;
        tick(7);
        chk("fast_clr", {31'd0, fast}, 32'd0);
        wait_step(40, n);
        chk("slow_again", n, 32'd8);
        key_rate_n = 1'b1;
        tick(5);

        // 4: bounce rejection on the run key
        for (int i = 0; i < 20;) begin
            int l;
            l = $urandom_range(1, 2);
            key_run_n = 1'b0;
            tick(l);
            i += l;
            l = $urandom_range(1, 2);
            key_run_n = 1'b1;
            tick(l);
            i += l;
        end
        chk("bounce_still_running", {31'd0, running}, 32'd1);
        key_run_n = 1'b0;
        tick(7);
        chk("bounce_stop", {31'd0, running}, 32'd0);
        sc = step_cnt;
        tick(100);
        chk("hold_running", {31'd0, running}, 32'd0);
        key_run_n = 1'b1;
        tick(20);
        chk("release_running", {31'd0, running}, 32'd0);
        chk("stopped_steps", step_cnt, sc);

        // 5: clear on terminal count
        key_run_n = 1'b0;
        tick(7);
        key_run_n = 1'b1;
        wait_step(40, n);
        chk("s5_first", n, 32'd8);
        tick(1);
        key_clr_n = 1'b0;
        tick(7);
        chk("tc_clear", {31'd0, clear}, 32'd1);
        chk("tc_nostep", {31'd0, step}, 32'd0);
        chk("tc_running", {31'd0, running}, 32'd1);
        key_clr_n = 1'b1;
        wait_step(40, n);
        chk("tc_next", n, 32'd8);

        // 6: stop, resume at retained rate, reset mid-run
        key_run_n = 1'b0;
        tick(7);
        chk("stop_running", {31'd0, running}, 32'd0);
        chk("stop_blink", {31'd0, blink}, 32'd0);
        sc = step_cnt;
        tick(30);
        chk("stop_nosteps", step_cnt, sc);
        key_run_n = 1'b1;
        tick(2);
        key_rate_n = 1'b0;
        tick(7);
        chk("stopped_rate", {31'd0, fast}, 32'd1);
        key_rate_n = 1'b1;
        tick(2);
        key_run_n = 1'b0;
        tick(7);
        chk("resume", {31'd0, running}, 32'd1);
        key_run_n = 1'b1;
        wait_step(40, n);
        chk("resume_fast", n, 32'd4);
        tick(2);
        reset = 1'b0;
        #1;
        chk("async_running", {31'd0, running}, 32'd0);
        chk("async_fast",    {31'd0, fast},    32'd0);
        chk("async_blink",   {31'd0, blink},   32'd0);
        chk("async_step",    {31'd0, step},    32'd0);
        key_run_n = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(6);
        chk("held_thru_rst6", {31'd0, running}, 32'd0);
        tick(1);
        chk("held_thru_rst7", {31'd0, running}, 32'd1);
        key_run_n = 1'b1;
        tick(10);

        // randomized key activity, one reset in the middle
        for (int k = 0; k < 3; k++) hold[k] = 0;
        for (int it = 0; it < 4000; it++) begin
            if (it == 2000) begin
                reset = 1'b0;
                tick(2);
                reset = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    lvl     = 1'($urandom_range(0, 1));
                    hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                          : $urandom_range(4, 40);
                    case (k)
                        0:       key_run_n  = lvl;
                        1:       key_rate_n = lvl;
                        default: key_clr_n  = lvl;
                    endcase
                end
                hold[k]--;
            end
            tick(1);
        end
        key_run_n  = 1'b1;
        key_rate_n = 1'b1;
        key_clr_n  = 1'b1;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
